// File: rtl/acs_scheduler.sv
// Time-multiplexed Viterbi trellis controller: one ACS swept over all states per step,
// ping-pong path-metric banks. Define ACS_NORM_EN to subtract the previous best metric on read.
module acs_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] pmc0_i,
  input  logic [W-1:0] pmc1_i,
  input  logic [1:0]   bm0_i,
  input  logic [1:0]   bm1_i,
  input  logic         vld0_i,
  input  logic         vld1_i,
  output logic [W-1:0] path_cost_o,
  output logic         valid_o,
  output logic         selection_o
);
  logic [W-1:0] sum0, sum1;

  assign sum0 = pmc0_i + W'(bm0_i);
  assign sum1 = pmc1_i + W'(bm1_i);

  // Ties go to path 0; an invalid result carries cost 0 and selection 0.
  always_comb begin
    selection_o = 1'b0;
    if (vld0_i && vld1_i) selection_o = (sum1 < sum0);
    else if (vld1_i)      selection_o = 1'b1;
    valid_o     = vld0_i | vld1_i;
    path_cost_o = !valid_o ? '0 : (selection_o ? sum1 : sum0);
  end
endmodule

module acs_scheduler #(
  parameter int             K        = 4,
  parameter logic [K-1:0]   G0       = 4'b1011,
  parameter logic [K-1:0]   G1       = 4'b1111,
  parameter int             METRIC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  step_valid,
  output logic                  step_ready,
  input  logic [7:0]            bmc_in,
  output logic                  surv_valid,
  output logic [2**(K-1)-1:0]   surv_bits,
  output logic [2**(K-1)-1:0]   state_valid,
  output logic [K-2:0]          best_state,
  output logic [METRIC_W-1:0]   best_metric,
  output logic                  busy
);
  localparam int NS = 2**(K-1);
  localparam int SW = K-1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic                  bank_sel_q;
  logic [METRIC_W-1:0]   metric_q [2][NS];
  logic [NS-1:0]         valid_q  [2];
  logic [7:0]            bmc_q;
  logic [SW-1:0]         idx_q;
  logic [NS-1:0]         surv_acc_q, vld_acc_q;
  logic                  min_found_q;
  logic [SW-1:0]         min_state_q;
  logic [METRIC_W-1:0]   min_metric_q;
  logic                  step_ready_q, busy_q, surv_valid_q;
  logic [NS-1:0]         surv_bits_q, state_valid_q;
  logic [SW-1:0]         best_state_q;
  logic [METRIC_W-1:0]   best_metric_q;
`ifdef ACS_NORM_EN
  logic [METRIC_W-1:0]   norm_min_q;
`endif

  logic [SW-1:0]         pred0, pred1;
  logic [K-1:0]          r0, r1;
  logic [1:0]            cw0, cw1;
  logic [1:0]            bm0, bm1;
  logic [METRIC_W-1:0]   pmc0, pmc1;
  logic [METRIC_W-1:0]   acs_cost;
  logic                  acs_vld, acs_sel;
  logic                  wr_bank;
  logic                  better;
  logic                  min_found_d;
  logic [SW-1:0]         min_state_d;
  logic [METRIC_W-1:0]   min_metric_d;
  logic [NS-1:0]         surv_d, vld_d;

  // Both predecessors of state s share s[K-3:0]; the input bit u is the MSB of s.
  assign pred0   = {idx_q[K-3:0], 1'b0};
  assign pred1   = {idx_q[K-3:0], 1'b1};
  assign r0      = {idx_q[K-2], pred0};
  assign r1      = {idx_q[K-2], pred1};
  assign cw0     = {^(r0 & G0), ^(r0 & G1)};
  assign cw1     = {^(r1 & G0), ^(r1 & G1)};
  assign bm0     = bmc_q[{cw0, 1'b0} +: 2];
  assign bm1     = bmc_q[{cw1, 1'b0} +: 2];
  assign wr_bank = ~bank_sel_q;

`ifdef ACS_NORM_EN
  assign pmc0 = metric_q[bank_sel_q][pred0] - norm_min_q;
  assign pmc1 = metric_q[bank_sel_q][pred1] - norm_min_q;
`else
  assign pmc0 = metric_q[bank_sel_q][pred0];
  assign pmc1 = metric_q[bank_sel_q][pred1];
`endif

  acs_unit #(.W(METRIC_W)) u_acs (
    .pmc0_i      (pmc0),
    .pmc1_i      (pmc1),
    .bm0_i       (bm0),
    .bm1_i       (bm1),
    .vld0_i      (valid_q[bank_sel_q][pred0]),
    .vld1_i      (valid_q[bank_sel_q][pred1]),
    .path_cost_o (acs_cost),
    .valid_o     (acs_vld),
    .selection_o (acs_sel)
  );

  // Strict less-than while sweeping upward keeps the lowest index on ties.
  always_comb begin
    better       = acs_vld && (!min_found_q || (acs_cost < min_metric_q));
    min_found_d  = min_found_q | acs_vld;
    min_state_d  = better ? idx_q : min_state_q;
    min_metric_d = better ? acs_cost : min_metric_q;
    surv_d         = surv_acc_q;
    surv_d[idx_q]  = acs_sel;
    vld_d          = vld_acc_q;
    vld_d[idx_q]   = acs_vld;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bank_sel_q    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < NS; s++) metric_q[b][s] <= '0;
        valid_q[b] <= NS'(1);
      end
      bmc_q         <= '0;
      idx_q         <= '0;
      surv_acc_q    <= '0;
      vld_acc_q     <= '0;
      min_found_q   <= 1'b0;
      min_state_q   <= '0;
      min_metric_q  <= '0;
      step_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
      surv_valid_q  <= 1'b0;
      surv_bits_q   <= '0;
      state_valid_q <= '0;
      best_state_q  <= '0;
      best_metric_q <= '0;
`ifdef ACS_NORM_EN
      norm_min_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          surv_valid_q <= 1'b0;
          if (frame_start) begin
            for (int s = 0; s < NS; s++) metric_q[bank_sel_q][s] <= '0;
            valid_q[bank_sel_q] <= NS'(1);
`ifdef ACS_NORM_EN
            norm_min_q <= '0;
`endif
          end
          if (step_valid) begin
            bmc_q        <= bmc_in;
            idx_q        <= '0;
            min_found_q  <= 1'b0;
            min_state_q  <= '0;
            min_metric_q <= '0;
            step_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          metric_q[wr_bank][idx_q] <= acs_cost;
          valid_q[wr_bank][idx_q]  <= acs_vld;
          surv_acc_q   <= surv_d;
          vld_acc_q    <= vld_d;
          min_found_q  <= min_found_d;
          min_state_q  <= min_state_d;
          min_metric_q <= min_metric_d;
          idx_q        <= idx_q + 1'b1;
          if (idx_q == SW'(NS-1)) begin
            surv_bits_q   <= surv_d;
            state_valid_q <= vld_d;
            best_state_q  <= min_found_d ? min_state_d : '0;
            best_metric_q <= min_found_d ? min_metric_d : '0;
            surv_valid_q  <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          bank_sel_q   <= ~bank_sel_q;
`ifdef ACS_NORM_EN
          norm_min_q   <= best_metric_q;
`endif
          surv_valid_q <= 1'b0;
          step_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_ready  = step_ready_q;
  assign busy        = busy_q;
  assign surv_valid  = surv_valid_q;
  assign surv_bits   = surv_bits_q;
  assign state_valid = state_valid_q;
  assign best_state  = best_state_q;
  assign best_metric = best_metric_q;
endmodule

// File: tb/tb_acs_scheduler.sv
// Randomized self-checking bench for acs_scheduler against a trellis-level reference model.
// Honors ACS_NORM_EN the same way the design does.
module tb_acs_scheduler;
  localparam int K  = 4;
  localparam int NS = 8;
  localparam logic [3:0] G0 = 4'b1011;
  localparam logic [3:0] G1 = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       step_valid = 1'b0;
  logic [7:0] bmc_in = 8'h00;
  logic       step_ready, surv_valid, busy;
  logic [7:0] surv_bits, state_valid, best_metric;
  logic [2:0] best_state;

  always #5 clk = ~clk;

  acs_scheduler #(.K(K), .G0(G0), .G1(G1), .METRIC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .bmc_in      (bmc_in),
    .surv_valid  (surv_valid),
    .surv_bits   (surv_bits),
    .state_valid (state_valid),
    .best_state  (best_state),
    .best_metric (best_metric),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0] surv;
    logic [7:0] valid;
    logic [2:0] bs;
    logic [7:0] bm;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mm[NS];
  bit   mv[NS];
  int   norm_m;
  bit   norm_on;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  function automatic void model_init();
    for (int s = 0; s < NS; s++) begin
      mm[s] = 0;
      mv[s] = (s == 0);
    end
    norm_m = 0;
  endfunction

  // One trellis step: every state picks the cheaper of its two predecessors.
  function automatic exp_t model_step(input logic [7:0] b);
    exp_t e;
    int   nm[NS];
    bit   nv[NS];
    int   bi;
    bit   found;
    bi = int'(b);
    e.surv = 0; e.valid = 0; e.bs = 0; e.bm = 0;
    found = 0;
    for (int s = 0; s < NS; s++) begin
      int cost[2];
      bit ok[2];
      int u;
      bit sel;
      u = s / (NS / 2);
      for (int j = 0; j < 2; j++) begin
        int p;
        int cw;
        logic [3:0] rv;
        p  = (s % (NS / 2)) * 2 + j;
        rv = 4'(u * NS + p);
        cw = ($countones(rv & G0) % 2) * 2 + ($countones(rv & G1) % 2);
        cost[j] = ((mm[p] - norm_m) + ((bi >> (2 * cw)) & 3)) & 255;
        ok[j]   = mv[p];
      end
      if (ok[0] && ok[1]) sel = (cost[1] < cost[0]);
      else                sel = ok[1];
      nv[s] = ok[0] | ok[1];
      nm[s] = nv[s] ? cost[sel] : 0;
      e.surv[s]  = nv[s] ? sel : 1'b0;
      e.valid[s] = nv[s];
      if (nv[s] && (!found || nm[s] < int'(e.bm))) begin
        found = 1;
        e.bs  = 3'(s);
        e.bm  = 8'(nm[s]);
      end
    end
    for (int s = 0; s < NS; s++) begin
      mm[s] = nm[s];
      mv[s] = nv[s];
    end
    if (norm_on) norm_m = int'(e.bm);
    return e;
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so acceptance is decided here.
  always @(negedge clk) begin
    if (rst) begin
      if (surv_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_surv", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("surv_bits",   32'(surv_bits),   32'(mon_e.surv));
          check("state_valid", 32'(state_valid), 32'(mon_e.valid));
          check("best_state",  32'(best_state),  32'(mon_e.bs));
          check("best_metric", 32'(best_metric), 32'(mon_e.bm));
        end
      end
      if (step_ready) begin
        if (frame_start) model_init();
        if (step_valid) exp_q.push_back(model_step(bmc_in));
      end
    end
  end

  task automatic do_step(input logic [7:0] b, input logic fs, output int lat);
    int guard;
    guard = 0;
    while (!step_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!step_ready) check("ready_timeout", 32'd0, 32'd1);
    step_valid  = 1'b1;
    bmc_in      = b;
    frame_start = fs;
    @(posedge clk); #1;
    step_valid  = 1'b0;
    frame_start = 1'b0;
    bmc_in      = 8'($urandom);
    lat = 1;
    while (!surv_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!surv_valid) check("surv_timeout", 32'd0, 32'd1);
    $display("step bmc=%02h fs=%0d lat=%0d surv=%02h valid=%02h best=%0d/%0d",
             b, fs, lat, surv_bits, state_valid, best_state, best_metric);
  endtask

  task automatic check_first_step(input string tag);
    check({tag, "_surv"},  32'(surv_bits),   32'h00);
    check({tag, "_valid"}, 32'(state_valid), 32'h11);
    check({tag, "_bs"},    32'(best_state),  32'd0);
    check({tag, "_bm"},    32'(best_metric), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int last, cyc, pulses, guard;
`ifdef ACS_NORM_EN
    norm_on = 1'b1;
`else
    norm_on = 1'b0;
`endif
    model_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(step_ready), 32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_sv",    32'(surv_valid), 32'd0);
    check("rst_valid", 32'(state_valid), 32'd0);
    check("rst_bm",    32'(best_metric), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // First step after reset
    do_step(8'b11_00_00_00, 1'b0, lat);
    check("lat", 32'(lat), 32'(NS + 1));
    check_first_step("first");
    @(posedge clk); #1;
    check("ready_after", 32'(step_ready), 32'd1);
    check("sv_pulse",    32'(surv_valid), 32'd0);
    check("busy_after",  32'(busy),       32'd0);

    // Equal-cost predecessors after two warm-up steps
    do_step(8'h00, 1'b1, lat);
    do_step(8'h00, 1'b0, lat);
    do_step(8'h00, 1'b0, lat);
    check("tie_surv",  32'(surv_bits),   32'h00);
    check("tie_valid", 32'(state_valid), 32'hFF);
    check("tie_bs",    32'(best_state),  32'd0);

    // Random steps
    for (int i = 0; i < 20; i++) begin
      do_step(8'($urandom), 1'($urandom_range(0, 9) == 0), lat);
      check("rand_lat", 32'(lat), 32'(NS + 1));
    end

    // step_valid held high with changing bmc_in
    @(posedge clk); #1;
    while (!step_ready) begin @(posedge clk); #1; end
    last = -1; pulses = 0;
    for (cyc = 0; cyc < 45; cyc++) begin
      if (surv_valid) begin
        if (last >= 0) check("stream_gap", 32'(cyc - last), 32'(NS + 2));
        last = cyc;
        pulses++;
      end
      step_valid = 1'b1;
      bmc_in     = 8'($urandom);
      @(posedge clk); #1;
    end
    step_valid = 1'b0;
    check("stream_pulses", 32'(pulses >= 3), 32'd1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin @(posedge clk); #1; guard++; end
    check("stream_drain", 32'(exp_q.size()), 32'd0);

    // Reset pulsed in the middle of RUN
    while (!step_ready) begin @(posedge clk); #1; end
    step_valid = 1'b1; bmc_in = 8'h5A;
    @(posedge clk); #1;
    step_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    model_init();
    exp_q.delete();
    #2;
    check("mid_rst_ready", 32'(step_ready), 32'd1);
    check("mid_rst_busy",  32'(busy),       32'd0);
    check("mid_rst_sv",    32'(surv_valid), 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (surv_valid) pulses++;
    end
    check("mid_rst_nosurv", 32'(pulses), 32'd0);
    do_step(8'b11_00_00_00, 1'b0, lat);
    check_first_step("after_rst");

    // frame_start together with step_valid after five steps
    for (int i = 0; i < 5; i++) do_step(8'($urandom), 1'b0, lat);
    do_step(8'b11_00_00_00, 1'b1, lat);
    check_first_step("reframe");

    // Long run with every branch metric at 3
    for (int n = 1; n <= 100; n++) begin
      do_step(8'hFF, 1'(n == 1), lat);
      check("ff_best", 32'(best_metric), norm_on ? 32'd3 : 32'((3 * n) % 256));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
